// File: rtl/cursor_brush.sv
// cursor_brush
// Moves a square SIZE x SIZE cursor around a W_RES x H_RES screen using four
// active-low direction buttons. Buttons are sampled once per move tick, which
// also debounces them. Holding a button auto-repeats after REPEAT_TICKS ticks.
// A paint button stamps the cursor footprint into the RGB frame buffers as a
// row-major burst of write strobes. The overlay flag marks scan positions that
// fall inside the cursor so the VGA path can draw it over the buffer contents.
//
// Ports:
//   CLOCK_50                  system clock, all state on the rising edge
//   reset                     asynchronous, active-low (0 = reset)
//   up_but/down_but/
//   left_but/right_but        direction buttons, active-low
//   paint_but                 paint request, active-low
//   x_coord, y_coord          current VGA scan position
//   cursor_x, cursor_y        cursor top-left corner
//   overlay                   scan position lies inside the cursor
//   wr_en                     frame-buffer write strobe
//   wr_x, wr_y                write address
//   wr_r, wr_g, wr_b          write data (zero whenever wr_en is low)
//   busy                      paint burst in progress
module cursor_brush #(
   parameter int          W_RES        = 640,
   parameter int          H_RES        = 480,
   parameter int          SIZE         = 16,
   parameter int          STEP         = 16,
   parameter int          DIVISOR      = 200000,
   parameter int          REPEAT_TICKS = 4,
   parameter logic [23:0] COLOR        = 24'h000000
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        up_but,
   input  logic        down_but,
   input  logic        left_but,
   input  logic        right_but,
   input  logic        paint_but,
   input  logic [10:0] x_coord,
   input  logic [10:0] y_coord,
   output logic [10:0] cursor_x,
   output logic [10:0] cursor_y,
   output logic        overlay,
   output logic        wr_en,
   output logic [10:0] wr_x,
   output logic [10:0] wr_y,
   output logic [7:0]  wr_r,
   output logic [7:0]  wr_g,
   output logic [7:0]  wr_b,
   output logic        busy
);

   localparam int TICK_W = $clog2(DIVISOR);
   localparam int HOLD_W = $clog2(REPEAT_TICKS + 1);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIVISOR - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(REPEAT_TICKS);

   localparam logic [10:0] MAX_X   = 11'(W_RES - SIZE);
   localparam logic [10:0] MAX_Y   = 11'(H_RES - SIZE);
   localparam logic [10:0] HOME_X  = 11'((W_RES - SIZE) / 2);
   localparam logic [10:0] HOME_Y  = 11'((H_RES - SIZE) / 2);
   localparam logic [10:0] STEP11  = 11'(STEP);
   localparam logic [10:0] SIZE_M1 = 11'(SIZE - 1);

   localparam logic [7:0] COLOR_R = COLOR[23:16];
   localparam logic [7:0] COLOR_G = COLOR[15:8];
   localparam logic [7:0] COLOR_B = COLOR[7:0];

   typedef enum logic [2:0] {
      DIR_NONE,
      DIR_UP,
      DIR_DOWN,
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   typedef enum logic {
      ST_IDLE,
      ST_PAINT
   } paint_state_t;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;

   dir_t              sel_dir;
   dir_t              last_dir;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_next;
   logic              do_step;

   logic [11:0]       x_plus;
   logic [11:0]       y_plus;
   logic [10:0]       x_left;
   logic [10:0]       x_right;
   logic [10:0]       y_up;
   logic [10:0]       y_down;

   paint_state_t      state;
   logic [10:0]       org_x;
   logic [10:0]       org_y;
   logic [10:0]       col_i;
   logic [10:0]       row_j;

   // Free-running move-tick divider. The tick is the single cycle in which
   // the counter sits at its last value; everything button-related happens
   // only on that cycle.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   // Fixed-priority direction pick: up beats down beats left beats right.
   always_comb begin
      sel_dir = DIR_NONE;
      if (!up_but) begin
         sel_dir = DIR_UP;
      end else if (!down_but) begin
         sel_dir = DIR_DOWN;
      end else if (!left_but) begin
         sel_dir = DIR_LEFT;
      end else if (!right_but) begin
         sel_dir = DIR_RIGHT;
      end
   end

   // Press-versus-hold decision. A new direction steps at once and restarts
   // the hold count; the same direction only steps once the saturating hold
   // count has reached the repeat threshold.
   always_comb begin
      hold_next = hold_cnt;
      do_step   = 1'b0;
      if (sel_dir == DIR_NONE) begin
         hold_next = '0;
      end else if (sel_dir != last_dir) begin
         hold_next = '0;
         do_step   = 1'b1;
      end else begin
         if (hold_cnt < HOLD_MAX) begin
            hold_next = hold_cnt + HOLD_W'(1);
         end
         do_step = (hold_next >= HOLD_MAX);
      end
   end

   // Clamped step targets. The additions are done one bit wider so a step
   // near the top of the 11-bit range cannot wrap past the clamp.
   always_comb begin
      x_plus  = {1'b0, cursor_x} + {1'b0, STEP11};
      y_plus  = {1'b0, cursor_y} + {1'b0, STEP11};
      x_left  = (cursor_x < STEP11) ? 11'd0 : (cursor_x - STEP11);
      y_up    = (cursor_y < STEP11) ? 11'd0 : (cursor_y - STEP11);
      x_right = (x_plus > {1'b0, MAX_X}) ? MAX_X : x_plus[10:0];
      y_down  = (y_plus > {1'b0, MAX_Y}) ? MAX_Y : y_plus[10:0];
   end

   // Cursor position and hold tracking, updated on the edge that ends a tick.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         cursor_x <= HOME_X;
         cursor_y <= HOME_Y;
         last_dir <= DIR_NONE;
         hold_cnt <= '0;
      end else if (tick) begin
         last_dir <= sel_dir;
         hold_cnt <= hold_next;
         if (do_step) begin
            case (sel_dir)
               DIR_UP:    cursor_y <= y_up;
               DIR_DOWN:  cursor_y <= y_down;
               DIR_LEFT:  cursor_x <= x_left;
               DIR_RIGHT: cursor_x <= x_right;
               default:   ;
            endcase
         end
      end
   end

   // Overlay compares are widened so cursor + SIZE - 1 cannot wrap.
   assign overlay = ({1'b0, x_coord} >= {1'b0, cursor_x}) &&
                    ({1'b0, x_coord} <= ({1'b0, cursor_x} + {1'b0, SIZE_M1})) &&
                    ({1'b0, y_coord} >= {1'b0, cursor_y}) &&
                    ({1'b0, y_coord} <= ({1'b0, cursor_y} + {1'b0, SIZE_M1}));

   // Paint burst. The origin is captured from the cursor registers on the
   // paint tick, so it is the pre-step position even if a move acts on the
   // same tick. The write outputs are loaded one address ahead: the value on
   // wr_x/wr_y is always the write currently being presented, and col_i/row_j
   // track which footprint cell that is. Requests arriving mid-burst are
   // simply not looked at.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         org_x <= '0;
         org_y <= '0;
         col_i <= '0;
         row_j <= '0;
         wr_en <= 1'b0;
         busy  <= 1'b0;
         wr_x  <= '0;
         wr_y  <= '0;
         wr_r  <= '0;
         wr_g  <= '0;
         wr_b  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (tick && !paint_but) begin
                  state <= ST_PAINT;
                  org_x <= cursor_x;
                  org_y <= cursor_y;
                  col_i <= '0;
                  row_j <= '0;
                  wr_en <= 1'b1;
                  busy  <= 1'b1;
                  wr_x  <= cursor_x;
                  wr_y  <= cursor_y;
                  wr_r  <= COLOR_R;
                  wr_g  <= COLOR_G;
                  wr_b  <= COLOR_B;
               end
            end
            ST_PAINT: begin
               if ((col_i == SIZE_M1) && (row_j == SIZE_M1)) begin
                  state <= ST_IDLE;
                  wr_en <= 1'b0;
                  busy  <= 1'b0;
                  wr_x  <= '0;
                  wr_y  <= '0;
                  wr_r  <= '0;
                  wr_g  <= '0;
                  wr_b  <= '0;
               end else if (col_i == SIZE_M1) begin
                  col_i <= '0;
                  row_j <= row_j + 11'd1;
                  wr_x  <= org_x;
                  wr_y  <= org_y + row_j + 11'd1;
               end else begin
                  col_i <= col_i + 11'd1;
                  wr_x  <= org_x + col_i + 11'd1;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cursor_brush.sv
// tb_cursor_brush
// Directed self-checking bench for cursor_brush using a small screen
// (32x24, 4-pixel cursor and step, 4-cycle tick, repeat after 2 ticks).
// All expected values are hand-computed constants.
module tb_cursor_brush;

   localparam int          W_RES        = 32;
   localparam int          H_RES        = 24;
   localparam int          SIZE         = 4;
   localparam int          STEP         = 4;
   localparam int          DIVISOR      = 4;
   localparam int          REPEAT_TICKS = 2;
   localparam logic [23:0] COLOR        = 24'hFF8000;

   logic        CLOCK_50 = 1'b0;
   logic        reset    = 1'b1;
   logic        up_but   = 1'b1;
   logic        down_but = 1'b1;
   logic        left_but = 1'b1;
   logic        right_but = 1'b1;
   logic        paint_but = 1'b1;
   logic [10:0] x_coord  = '0;
   logic [10:0] y_coord  = '0;
   logic [10:0] cursor_x;
   logic [10:0] cursor_y;
   logic        overlay;
   logic        wr_en;
   logic [10:0] wr_x;
   logic [10:0] wr_y;
   logic [7:0]  wr_r;
   logic [7:0]  wr_g;
   logic [7:0]  wr_b;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   cursor_brush #(
      .W_RES        (W_RES),
      .H_RES        (H_RES),
      .SIZE         (SIZE),
      .STEP         (STEP),
      .DIVISOR      (DIVISOR),
      .REPEAT_TICKS (REPEAT_TICKS),
      .COLOR        (COLOR)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .up_but    (up_but),
      .down_but  (down_but),
      .left_but  (left_but),
      .right_but (right_but),
      .paint_but (paint_but),
      .x_coord   (x_coord),
      .y_coord   (y_coord),
      .cursor_x  (cursor_x),
      .cursor_y  (cursor_y),
      .overlay   (overlay),
      .wr_en     (wr_en),
      .wr_x      (wr_x),
      .wr_y      (wr_y),
      .wr_r      (wr_r),
      .wr_g      (wr_g),
      .wr_b      (wr_b),
      .busy      (busy)
   );

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Button levels, active-low, in the order up, down, left, right, paint.
   task automatic applyStimulus(input logic up, input logic down, input logic left,
                                input logic right, input logic paint);
      up_but    = up;
      down_but  = down;
      left_but  = left;
      right_but = right;
      paint_but = paint;
   endtask

   task automatic checkCursor(input string tag, input int ex, input int ey);
      checkOutput({tag, "_x"}, 32'(cursor_x), ex);
      checkOutput({tag, "_y"}, 32'(cursor_y), ey);
   endtask

   // Advances to 1ns past the next tick-ending edge.
   task automatic runTick();
      repeat (DIVISOR) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic nextCycle();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Resets with buttons released; release lands on a falling edge so the
   // following DIVISOR rising edges end exactly at the first tick.
   task automatic doReset();
      applyStimulus(1, 1, 1, 1, 1);
      reset = 1'b0;
      #3;
      @(negedge CLOCK_50);
      reset = 1'b1;
   endtask

   initial begin
      int exp_y_up[4]   = '{6, 6, 2, 0};
      int exp_y_down[5] = '{14, 14, 18, 20, 20};
      int exp_x_right[6] = '{18, 18, 22, 26, 28, 28};

      // Reset values while reset is held, then overlay boundaries.
      #1 reset = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      checkCursor("rst_cursor", 14, 10);
      checkOutput("rst_wr_en", 32'(wr_en), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_wr_r", 32'(wr_r), 0);
      reset = 1'b1;
      x_coord = 11'd17; y_coord = 11'd13; #1;
      checkOutput("ovl_in_corner", 32'(overlay), 1);
      x_coord = 11'd18; #1;
      checkOutput("ovl_right_out", 32'(overlay), 0);
      x_coord = 11'd14; y_coord = 11'd14; #1;
      checkOutput("ovl_below_out", 32'(overlay), 0);
      x_coord = 11'd14; y_coord = 11'd10; #1;
      checkOutput("ovl_origin_in", 32'(overlay), 1);

      // Single up press, then released.
      doReset();
      applyStimulus(0, 1, 1, 1, 1);
      runTick();
      checkCursor("up_once", 14, 6);
      applyStimulus(1, 1, 1, 1, 1);
      runTick();
      checkCursor("up_released1", 14, 6);
      runTick();
      checkCursor("up_released2", 14, 6);

      // Up held: step, wait, repeat, clamp at 0; re-press stays at 0.
      doReset();
      applyStimulus(0, 1, 1, 1, 1);
      for (int k = 0; k < 4; k++) begin
         runTick();
         checkOutput($sformatf("up_hold_t%0d", k), 32'(cursor_y), exp_y_up[k]);
      end
      applyStimulus(1, 1, 1, 1, 1);
      runTick();
      checkOutput("up_release_y", 32'(cursor_y), 0);
      applyStimulus(0, 1, 1, 1, 1);
      runTick();
      checkOutput("up_repress_y", 32'(cursor_y), 0);

      // All buttons low: up has priority.
      doReset();
      applyStimulus(0, 0, 0, 0, 1);
      runTick();
      checkCursor("prio_up", 14, 6);

      // Down held clamps at H_RES - SIZE = 20.
      doReset();
      applyStimulus(1, 0, 1, 1, 1);
      for (int k = 0; k < 5; k++) begin
         runTick();
         checkOutput($sformatf("down_hold_t%0d", k), 32'(cursor_y), exp_y_down[k]);
      end

      // Left over right when both low.
      doReset();
      applyStimulus(1, 1, 0, 0, 1);
      runTick();
      checkCursor("left_once", 10, 10);

      // Right held clamps at W_RES - SIZE = 28.
      doReset();
      applyStimulus(1, 1, 1, 0, 1);
      for (int k = 0; k < 6; k++) begin
         runTick();
         checkOutput($sformatf("right_hold_t%0d", k), 32'(cursor_x), exp_x_right[k]);
      end
      x_coord = 11'd31; y_coord = 11'd13; #1;
      checkOutput("ovl_right_edge_in", 32'(overlay), 1);
      x_coord = 11'd27; #1;
      checkOutput("ovl_left_of_cursor", 32'(overlay), 0);

      // Paint burst at (14,10), with a second request held over two ticks
      // inside the burst that must be ignored.
      doReset();
      applyStimulus(1, 1, 1, 1, 0);
      runTick();
      for (int k = 0; k < 16; k++) begin
         checkOutput($sformatf("paint_en_w%0d", k), 32'(wr_en), 1);
         checkOutput($sformatf("paint_busy_w%0d", k), 32'(busy), 1);
         checkOutput($sformatf("paint_x_w%0d", k), 32'(wr_x), 14 + (k % 4));
         checkOutput($sformatf("paint_y_w%0d", k), 32'(wr_y), 10 + (k / 4));
         if (k == 0 || k == 15) begin
            checkOutput($sformatf("paint_r_w%0d", k), 32'(wr_r), 32'hFF);
            checkOutput($sformatf("paint_g_w%0d", k), 32'(wr_g), 32'h80);
            checkOutput($sformatf("paint_b_w%0d", k), 32'(wr_b), 32'h00);
         end
         if (k == 1) applyStimulus(1, 1, 1, 1, 0);
         else if (k == 10) applyStimulus(1, 1, 1, 1, 1);
         else if (k == 0) applyStimulus(1, 1, 1, 1, 1);
         nextCycle();
      end
      for (int k = 0; k < 5; k++) begin
         checkOutput($sformatf("paint_done_en_c%0d", k), 32'(wr_en), 0);
         checkOutput($sformatf("paint_done_busy_c%0d", k), 32'(busy), 0);
         checkOutput($sformatf("paint_done_r_c%0d", k), 32'(wr_r), 0);
         nextCycle();
      end

      // Move right and paint on the same tick, then reset during write 7.
      doReset();
      applyStimulus(1, 1, 1, 0, 0);
      runTick();
      applyStimulus(1, 1, 1, 1, 1);
      checkCursor("mvpaint_cursor", 18, 10);
      checkOutput("mvpaint_wr_x", 32'(wr_x), 14);
      checkOutput("mvpaint_wr_y", 32'(wr_y), 10);
      checkOutput("mvpaint_wr_en", 32'(wr_en), 1);
      repeat (6) nextCycle();
      checkOutput("w7_wr_x", 32'(wr_x), 16);
      checkOutput("w7_wr_y", 32'(wr_y), 11);
      checkOutput("w7_wr_en", 32'(wr_en), 1);
      #2 reset = 1'b0;
      #1;
      checkOutput("abort_wr_en", 32'(wr_en), 0);
      checkOutput("abort_busy", 32'(busy), 0);
      checkOutput("abort_wr_x", 32'(wr_x), 0);
      checkCursor("abort_cursor", 14, 10);
      @(negedge CLOCK_50);
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         nextCycle();
         checkOutput($sformatf("post_abort_en_c%0d", k), 32'(wr_en), 0);
      end
      applyStimulus(1, 1, 1, 1, 0);
      runTick();
      applyStimulus(1, 1, 1, 1, 1);
      checkOutput("repaint_en", 32'(wr_en), 1);
      checkOutput("repaint_x", 32'(wr_x), 14);
      checkOutput("repaint_y", 32'(wr_y), 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cursor_brush.md
# cursor_brush

Parametrised successor to the button-driven ball in the top level. Moves a square cursor on a W_RES×H_RES screen from four active-low buttons, with tick-based debounce, hold-to-repeat and clamping that keeps the cursor fully on screen. A paint button stamps the cursor footprint into the RGB frame buffers as a row-major burst of write strobes. A combinational overlay flag lets the VGA path draw the cursor over buffer contents.

## Interface
- W_RES, 640: horizontal resolution in pixels.
- H_RES, 480: vertical resolution in pixels.
- SIZE, 16: cursor edge in pixels (cursor covers SIZE×SIZE); ≥1, ≤ min(W_RES, H_RES).
- STEP, 16: pixels moved per step; ≥1.
- DIVISOR, 200000: CLOCK_50 cycles per move tick; ≥2.
- REPEAT_TICKS, 4: held ticks before auto-repeat starts; ≥1.
- COLOR, 24'h000000: paint colour {R,G,B}.

Ports:
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- up_but, down_but, left_but, right_but  in  1 each  direction buttons, active-low.
- paint_but  in  1  paint request, active-low.
- x_coord, y_coord  in  11 each  current VGA scan position.
- cursor_x, cursor_y  out  11 each  cursor top-left corner.
- overlay  out  1  high when the scan position is inside the cursor.
- wr_en  out  1  frame-buffer write strobe.
- wr_x, wr_y  out  11 each  write address.
- wr_r, wr_g, wr_b  out  8 each  write data.
- busy  out  1  paint burst in progress.

## Operation
- Tick counter runs 0..DIVISOR-1 and wraps. The tick is the single cycle in which the counter equals DIVISOR-1. Buttons are sampled only in tick cycles, which provides the debounce.
- Direction select at a tick uses fixed priority up > down > left > right. "None" means no direction button is low.
- Press vs hold:
  - The selected direction differs from the one latched at the previous tick (including from none): immediate step; hold counter ← 0.
  - Same direction as the previous tick: the hold counter increments, saturating at REPEAT_TICKS. A step occurs when the incremented value ≥ REPEAT_TICKS.
  - None: no step; hold counter ← 0.
- Step arithmetic is 11-bit unsigned and clamps so the cursor stays fully visible:
  - up: y < STEP → 0, else y − STEP.
  - down: y + STEP > H_RES − SIZE → H_RES − SIZE, else y + STEP.
  - left and right follow the same rules using x, W_RES.
- Overlay (combinational): x_coord ∈ [cursor_x, cursor_x+SIZE−1] and y_coord ∈ [cursor_y, cursor_y+SIZE−1].
- Paint FSM has two states, IDLE and PAINT.
  - IDLE → PAINT: tick cycle with paint_but low. The origin latched is the cursor position before that tick's step.
  - PAINT: one write per cycle, row-major. Column index i runs 0..SIZE−1 fastest, then row j. Outputs: wr_x = origin_x + i, wr_y = origin_y + j, wr_{r,g,b} = COLOR.
  - PAINT → IDLE: after write (SIZE−1, SIZE−1).
  - A paint request on a tick while in PAINT is dropped.
  - Cursor movement continues during PAINT; the burst keeps using the latched origin.
- Reset (asynchronous, any time, including mid-burst) aborts the burst immediately. Reset values:
  - cursor_x = (W_RES−SIZE)/2, cursor_y = (H_RES−SIZE)/2, integer division.
  - wr_en, busy, wr_x, wr_y, wr_r, wr_g, wr_b = 0.
  - FSM = IDLE; tick counter, hold counter and latched direction cleared.

## Timing
- Cursor registers update on the clock edge ending the tick cycle; the new value is visible one cycle after the tick.
- overlay has zero latency from x_coord, y_coord and the cursor registers.
- Write outputs are registered:
  - First wr_en is asserted the cycle after the paint tick.
  - wr_en stays high for exactly SIZE×SIZE consecutive cycles.
  - busy is high over exactly the same cycles as wr_en.
  - wr_r, wr_g, wr_b are 0 whenever wr_en is low.
- Move and paint in the same tick: both act. The burst uses the pre-step position; the cursor shows the post-step position.

## Test plan
Bench parameters: W_RES=32, H_RES=24, SIZE=4, STEP=4, DIVISOR=4, REPEAT_TICKS=2, COLOR=24'hFF8000.
- Reset release → cursor (14,10), wr_en=0, busy=0, overlay=1 at scan (17,13), overlay=0 at (18,13) and at (14,14).
- up_but low for one tick then released → cursor_y 10→6; no further change on later ticks.
- up_but held for 4 ticks → cursor_y per tick: 6, 6, 2, 0 (clamped); releasing and pressing again moves 0→0.
- right_but held from x=14 → per tick: 18, 18, 22, 26, 28 (clamped at W_RES−SIZE), then stays at 28.
- paint_but low for one tick at (14,10) → 16 consecutive wr_en cycles, first (14,10), fifth (14,11), last (17,13), data FF/80/00; second paint tick during the burst is ignored.
- Reset asserted during the 7th write → wr_en and busy low asynchronously, cursor back to (14,10), no further writes after release until a new paint tick.
